// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester and Avalon-MM controller signals around the SDRAM port arbiter.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              iRD_REQ;
  logic [ADDR_W-1:0] iRD_ADDR;
  logic              oRD_WAIT;
  logic [DATA_W-1:0] oRD_DATA;
  logic              oRD_DATAVALID;
  logic              iWR_REQ;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic [DATA_W-1:0] iWR_DATA;
  logic              oWR_WAIT;
  logic [ADDR_W-1:0] oAVM_ADDR;
  logic              oAVM_READ;
  logic              oAVM_WRITE;
  logic [DATA_W-1:0] oAVM_WRITEDATA;
  logic              iAVM_WAITREQUEST;
  logic [DATA_W-1:0] iAVM_READDATA;
  logic              iAVM_READDATAVALID;
  modport master (
    input  iRD_REQ, iRD_ADDR, iWR_REQ, iWR_ADDR, iWR_DATA,
           iAVM_WAITREQUEST, iAVM_READDATA, iAVM_READDATAVALID,
    output oRD_WAIT, oRD_DATA, oRD_DATAVALID, oWR_WAIT,
           oAVM_ADDR, oAVM_READ, oAVM_WRITE, oAVM_WRITEDATA
  );
  modport slave (
    output iRD_REQ, iRD_ADDR, iWR_REQ, iWR_ADDR, iWR_DATA,
           iAVM_WAITREQUEST, iAVM_READDATA, iAVM_READDATAVALID,
    input  oRD_WAIT, oRD_DATA, oRD_DATAVALID, oWR_WAIT,
           oAVM_ADDR, oAVM_READ, oAVM_WRITE, oAVM_WRITEDATA
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: read-priority arbiter with bounded read streak sharing one SDRAM Avalon-MM port.
// Define SDRAM_ARB_STATS_EN to add saturating read/write/stall counters.
module sdram_port_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int MAX_PEND  = 4,
  parameter int RD_STREAK = 8
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  sdram_port_arbiter_if.master bus,
  output logic [3:0]          oPEND
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]         oSTAT_RD,
  output logic [15:0]         oSTAT_WR,
  output logic [15:0]         oSTAT_STALL
`endif
);
  localparam int SW = $clog2(RD_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(RD_STREAK);
  localparam logic [3:0] PEND_MAX = 4'(MAX_PEND);
  typedef enum logic [1:0] {ST_IDLE, ST_GNT_RD, ST_GNT_WR} state_t;
  state_t state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [SW-1:0] streak_q, streak_d;
  logic rdv_q;
  logic [DATA_W-1:0] rdata_q;
  logic rd_acc, wr_acc, dv_ok;
  // arbitration looks at post-update pend/streak so a grant never overshoots either limit
  always_comb begin
    rd_acc = state_q == ST_GNT_RD && !bus.iAVM_WAITREQUEST;
    wr_acc = state_q == ST_GNT_WR && !bus.iAVM_WAITREQUEST;
    dv_ok = bus.iAVM_READDATAVALID && pend_q != 4'd0;
    pend_d = pend_q + {3'd0, rd_acc} - {3'd0, dv_ok};
    streak_d = wr_acc ? '0 : !rd_acc ? streak_q : !bus.iWR_REQ ? '0 :
               streak_q == STREAK_MAX ? streak_q : streak_q + 1'b1;
    state_d = state_q;
    if (state_q == ST_IDLE || rd_acc || wr_acc)
      state_d = (bus.iRD_REQ && pend_d < PEND_MAX && !(bus.iWR_REQ && streak_d == STREAK_MAX)) ? ST_GNT_RD :
                bus.iWR_REQ ? ST_GNT_WR : ST_IDLE;
  end
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      streak_q <= '0;
      rdv_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      streak_q <= streak_d;
      rdv_q    <= dv_ok;
      rdata_q  <= bus.iAVM_READDATA;
    end
  end
  assign bus.oAVM_READ      = state_q == ST_GNT_RD;
  assign bus.oAVM_WRITE     = state_q == ST_GNT_WR;
  assign bus.oAVM_ADDR      = bus.oAVM_READ ? bus.iRD_ADDR : bus.oAVM_WRITE ? bus.iWR_ADDR : '0;
  assign bus.oAVM_WRITEDATA = bus.oAVM_WRITE ? bus.iWR_DATA : '0;
  assign bus.oRD_WAIT       = bus.oAVM_READ ? bus.iAVM_WAITREQUEST : 1'b1;
  assign bus.oWR_WAIT       = bus.oAVM_WRITE ? bus.iAVM_WAITREQUEST : 1'b1;
  assign bus.oRD_DATAVALID  = rdv_q;
  assign bus.oRD_DATA       = rdata_q;
  assign oPEND              = pend_q;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] st_rd_q, st_wr_q, st_stall_q;
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      st_rd_q    <= '0;
      st_wr_q    <= '0;
      st_stall_q <= '0;
    end else begin
      if (rd_acc && st_rd_q != 16'hFFFF) st_rd_q <= st_rd_q + 16'd1;
      if (wr_acc && st_wr_q != 16'hFFFF) st_wr_q <= st_wr_q + 16'd1;
      if (state_q != ST_IDLE && bus.iAVM_WAITREQUEST && st_stall_q != 16'hFFFF) st_stall_q <= st_stall_q + 16'd1;
    end
  end
  assign oSTAT_RD    = st_rd_q;
  assign oSTAT_WR    = st_wr_q;
  assign oSTAT_STALL = st_stall_q;
`endif
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single Avalon-MM master port of the SDRAM controller between two requesters: a frame loader (write-only) and a display/readback fetcher (read-only).
- Read priority with a bounded read streak, so writes cannot starve.
- Tracks outstanding (pipelined) reads and routes read data back to the read requester.
- Sits between the requester blocks and the SDRAM controller's 25-bit word-addressed, 16-bit data port.

Parameters:
- ADDR_W, 25, address width (words).
- DATA_W, 16, data width.
- MAX_PEND, 4, maximum outstanding reads (1..15).
- RD_STREAK, 8, consecutive read grants allowed while a write is waiting (>=1).

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  synchronous reset, active low.
- iRD_REQ  in  1  read request; held until accepted.
- iRD_ADDR  in  ADDR_W  read address; stable while iRD_REQ is high.
- oRD_WAIT  out  1  read not accepted this cycle.
- oRD_DATA  out  DATA_W  returned read data.
- oRD_DATAVALID  out  1  oRD_DATA is valid.
- iWR_REQ  in  1  write request; held until accepted.
- iWR_ADDR  in  ADDR_W  write address.
- iWR_DATA  in  DATA_W  write data.
- oWR_WAIT  out  1  write not accepted this cycle.
- oAVM_ADDR  out  ADDR_W  to controller.
- oAVM_READ  out  1  to controller.
- oAVM_WRITE  out  1  to controller.
- oAVM_WRITEDATA  out  DATA_W  to controller.
- iAVM_WAITREQUEST  in  1  from controller.
- iAVM_READDATA  in  DATA_W  from controller.
- iAVM_READDATAVALID  in  1  from controller.
- oPEND  out  4  current outstanding-read count.

Behaviour:
- **Reset** (iRST_N=0 at a clock edge):
  - state=ST_IDLE, pend=0, streak=0.
  - oAVM_READ=oAVM_WRITE=0; oRD_WAIT=oWR_WAIT=1; oRD_DATAVALID=0; oPEND=0.
  - oAVM_ADDR, oAVM_WRITEDATA and oRD_DATA drive 0.
  - A reset mid-transfer abandons the transfer; the requester must re-issue it.
- **States:** ST_IDLE, ST_GNT_RD, ST_GNT_WR (registered grant).
- **Grant decision (arb)**, evaluated in ST_IDLE and on each acceptance cycle:
  - rd_ok = iRD_REQ && pend < MAX_PEND.
  - If rd_ok && !(iWR_REQ && streak == RD_STREAK): grant read.
  - Else if iWR_REQ: grant write.
  - Else: ST_IDLE.
- **ST_GNT_RD:**
  - oAVM_READ=1; oAVM_ADDR=iRD_ADDR; oRD_WAIT=iAVM_WAITREQUEST; oWR_WAIT=1.
  - Accept = !iAVM_WAITREQUEST; on accept, next state = arb.
  - Grant is held while waitrequest is asserted, even if a write arrives.
- **ST_GNT_WR:**
  - oAVM_WRITE=1; oAVM_ADDR=iWR_ADDR; oAVM_WRITEDATA=iWR_DATA; oWR_WAIT=iAVM_WAITREQUEST; oRD_WAIT=1.
  - On accept, next state = arb.
- **Idle outputs:** in ST_IDLE the master strobes are 0 and both waits are 1, so the first transfer after idle has 1 cycle of arbitration latency. Back-to-back accepted transfers then sustain 1 per cycle.
- **streak counter:**
  - +1 on each accepted read while iWR_REQ is high, saturating at RD_STREAK.
  - Cleared to 0 on each accepted write.
  - Cleared to 0 on any accepted read while iWR_REQ is low.
- **pend counter:**
  - +1 on read accept; -1 on iAVM_READDATAVALID.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds MAX_PEND, because read grants are blocked at MAX_PEND.
  - A datavalid arriving with pend=0 (stray beat, e.g. after reset) is dropped: no decrement and no oRD_DATAVALID.
- **Read return:** registered, 1 cycle latency. oRD_DATAVALID(t+1) = iAVM_READDATAVALID(t) && pend(t) != 0, and oRD_DATA(t+1) = iAVM_READDATA(t). Data is returned in issue order.
- **Requester contract:** requesters must not drop a request before acceptance. Behaviour when a request is withdrawn during a grant: the grant state stays until waitrequest goes low, then re-arbitrates. The strobe is still driven, so a withdrawn request risks a spurious transfer; the requester contract forbids withdrawal.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- **Defined:** adds outputs oSTAT_RD[15:0], oSTAT_WR[15:0] and oSTAT_STALL[15:0].
  - oSTAT_RD counts accepted reads; oSTAT_WR counts accepted writes.
  - oSTAT_STALL counts cycles with a grant state held and iAVM_WAITREQUEST=1.
  - All three saturate at 16'hFFFF and are cleared by reset.
- **Undefined:** those ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- **Reads only:** iRD_REQ held, waitrequest=0, datavalid returning 3 cycles after each accept.
  - Required: after the first cycle, 1 accept per cycle; oPEND climbs to 3 and holds.
  - Required: every beat appears on oRD_DATAVALID one cycle later, in order.
- **Pending limit:** reads with no datavalid returned.
  - Required: exactly 4 accepts, then oRD_WAIT stays 1 and oPEND=4.
  - Required: one datavalid pulse -> oPEND=3, then the next read is accepted.
- **Starvation guard:** iRD_REQ and iWR_REQ both continuously high, RD_STREAK=8.
  - Required: grant pattern is 8 reads, 1 write, repeating; streak returns to 0 after each write.
- **Waitrequest stall:** in ST_GNT_WR, waitrequest=1 for 5 cycles while iRD_REQ rises.
  - Required: write strobes, address and data are held for 6 cycles; oRD_WAIT=1 throughout; the write is accepted on cycle 6.
  - Required: the read is granted next.
- **Simultaneous events:** an accept and a datavalid in the same cycle at pend=2 -> pend stays 2. A datavalid with pend=0 -> no oRD_DATAVALID.
- **Reset mid-grant:** drive iRST_N=0 during ST_GNT_RD with pend=3.
  - Required: next cycle state=ST_IDLE, oPEND=0, strobes low.
  - Required: a subsequent late datavalid is dropped.
